// File: rtl/rep_sequencer_if.sv
// Execute-iteration handshake between the string-instruction sequencer (master)
// and the execute datapath (slave).
interface rep_sequencer_if;
  logic        exe_req;
  logic [31:0] exe_esi;
  logic [31:0] exe_edi;
  logic        exe_ack;
  logic [31:0] exe_eflags;

  modport master (
    output exe_req, exe_esi, exe_edi,
    input  exe_ack, exe_eflags
  );

  modport slave (
    input  exe_req, exe_esi, exe_edi,
    output exe_ack, exe_eflags
  );
endinterface

// File: rtl/rep_sequencer.sv
// Sequencer for MOVS/CMPS with optional REP/REPE/REPNE prefix: one execute
// handshake per element. Define REP_BOUND_EN to cap iterations at MAX_ITERS.
module rep_sequencer #(
  parameter int unsigned MAX_ITERS = 65536,
  parameter int unsigned ITER_W    = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        rep_kind,
  input  logic              is_cmps,
  input  logic [1:0]        opnd_size,
  input  logic [31:0]       ecx_in,
  input  logic [31:0]       esi_in,
  input  logic [31:0]       edi_in,
  input  logic [31:0]       eflags_in,
  rep_sequencer_if.master   exe,
  output logic [31:0]       ecx_out,
  output logic [31:0]       esi_out,
  output logic [31:0]       edi_out,
  output logic [31:0]       eflags_out,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy,
  output logic              done,
  output logic              bound_hit
);

`ifdef REP_BOUND_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_UPDATE,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    REP_NONE = 2'b00,
    REP_REP  = 2'b01,
    REP_E    = 2'b10,
    REP_NE   = 2'b11
  } rep_e;

  state_e              state_q;
  rep_e                kind_q;
  logic                cmps_q;
  logic [1:0]          size_q;
  logic                df_q;
  logic [31:0]         ecx_q, esi_q, edi_q, eflags_q;
  logic [ITER_W-1:0]   iter_q;
  logic                req_q, done_q, busy_q, bound_q;

  logic [31:0]         step;
  logic [31:0]         ecx_d, esi_d, edi_d;
  logic [ITER_W-1:0]   iter_d;
  logic                zf;
  logic                stop_d, bound_d;

  // Post-UPDATE values; termination is judged on these, not the current ones.
  always_comb begin
    step = 32'd4;
    unique case (size_q)
      2'b00:   step = 32'd1;
      2'b01:   step = 32'd2;
      default: step = 32'd4;
    endcase
    esi_d  = df_q ? (esi_q - step) : (esi_q + step);
    edi_d  = df_q ? (edi_q - step) : (edi_q + step);
    ecx_d  = (kind_q != REP_NONE) ? (ecx_q - 32'd1) : ecx_q;
    iter_d = iter_q + ITER_W'(1);
    zf     = eflags_q[6];
    stop_d = (kind_q == REP_NONE) || (ecx_d == '0) ||
             (cmps_q && (kind_q == REP_E)  && !zf) ||
             (cmps_q && (kind_q == REP_NE) &&  zf);
    bound_d = BOUND_EN && !stop_d && (iter_d == ITER_W'(MAX_ITERS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      kind_q   <= REP_NONE;
      cmps_q   <= 1'b0;
      size_q   <= '0;
      df_q     <= 1'b0;
      ecx_q    <= '0;
      esi_q    <= '0;
      edi_q    <= '0;
      eflags_q <= '0;
      iter_q   <= '0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      bound_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            kind_q   <= rep_e'(rep_kind);
            cmps_q   <= is_cmps;
            size_q   <= opnd_size;
            df_q     <= eflags_in[10];
            ecx_q    <= ecx_in;
            esi_q    <= esi_in;
            edi_q    <= edi_in;
            eflags_q <= eflags_in;
            iter_q   <= '0;
            bound_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if ((kind_q != REP_NONE) && (ecx_q == '0)) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (exe.exe_ack) begin
            req_q <= 1'b0;
            if (cmps_q) begin
              eflags_q <= exe.exe_eflags;
            end
            state_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          esi_q   <= esi_d;
          edi_q   <= edi_d;
          ecx_q   <= ecx_d;
          iter_q  <= iter_d;
          bound_q <= bound_d;
          if (stop_d || bound_d) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign exe.exe_req = req_q;
  assign exe.exe_esi = esi_q;
  assign exe.exe_edi = edi_q;

  assign ecx_out    = ecx_q;
  assign esi_out    = esi_q;
  assign edi_out    = edi_q;
  assign eflags_out = eflags_q;
  assign iter_count = iter_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bound_hit  = bound_q;

endmodule
